spi_host_ctrl: RTL and testbench
================================

Name: spi_host_ctrl

Overview:
SPI host (master) that turns a single Wishbone-style slave access into the two-frame command/data SPI sequence that spi_ctrl decodes.
- Frame 0 carries the command byte {we, addr[6:0]}; frame 1 carries the write data, or clocks out read data.
- Sits between the host-side register bus and the off-chip SPI pins; the counterpart of spi_ctrl at the other end of the link.

Parameters:
- CLK_DIV, 4, SCK half-period in clk cycles; legal range >= 1.
- SS_GAP, 4, clk cycles spi_ss is held high after each frame; legal range >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronised by the integrator.
- wb_addr_i  in  8  register address. Bits [6:0] are sent; bit 7 handling is set by the optional feature.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data returned from the slave.
- wb_stb_i  in  1  request strobe; held high until wb_ack_o.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_ack_o  out  1  one-cycle completion pulse.
- wb_err_o  out  1  error pulse; constant 0 unless SPI_HOST_ADDR_CHK_EN is defined.
- spi_sck  out  1  SPI clock; idles high.
- spi_mosi  out  1  host-to-slave data, MSB first.
- spi_miso  in  1  slave-to-host data.
- spi_ss  out  1  active-low slave select.

Behaviour:
- Reset values (reset=0, asynchronous): state IDLE, spi_ss=1, spi_sck=1, spi_mosi=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=8'h00, all counters 0.
- All outputs are registered.
- Request acceptance:
  - A request is accepted only in IDLE, on the rising edge where wb_stb_i=1.
  - addr[6:0], wb_dat_i and wb_we_i are captured into tx registers at acceptance.
  - Input changes after acceptance are ignored.
- State machine: IDLE -> F0_LEAD -> F0_SHIFT -> F0_TRAIL -> GAP0 -> F1_LEAD -> F1_SHIFT -> F1_TRAIL -> GAP1 -> ACK -> IDLE.
- LEAD state (CLK_DIV cycles): spi_ss=0, spi_sck=1, spi_mosi = bit 7 of the frame byte.
- SHIFT state (16*CLK_DIV cycles):
  - spi_sck toggles every CLK_DIV cycles, starting with a falling edge, giving 8 falling and 8 rising edges.
  - spi_miso is sampled into the rx shift register in the clk cycle that drives spi_sck low.
  - On each rising edge except the 8th, spi_mosi advances to the next lower bit.
- TRAIL state (CLK_DIV cycles): spi_sck=1, spi_ss=0, spi_mosi holds bit 0.
- GAP states (SS_GAP cycles each): spi_ss=1, spi_sck=1, spi_mosi=0.
- Frame byte values:
  - Frame 0 byte = {we, addr[6:0]}.
  - Frame 1 byte = wb_dat_i for a write, 8'h00 for a read.
- Receive data:
  - The rx byte from frame 0 is discarded.
  - On a read, the frame 1 rx byte is loaded into wb_dat_o in the ACK cycle.
  - On a write, wb_dat_o is unchanged.
- Timing:
  - spi_ss is low for 18*CLK_DIV cycles per frame.
  - wb_ack_o is high for exactly one cycle, 2*(18*CLK_DIV+SS_GAP)+1 cycles after the acceptance edge (153 at the defaults).
  - After ACK the block spends at least one cycle in IDLE before it can accept again. wb_stb_i still high in that cycle starts a new transaction.
- Reset mid-transaction: the outputs return to their reset values immediately; the partial frame is abandoned, with no ack and no err.
- A rising edge of spi_sck never coincides with a change of spi_ss; the LEAD and TRAIL states guarantee this.

Optional Feature:
- Macro SPI_HOST_ADDR_CHK_EN.
- Defined:
  - A request with wb_addr_i[7]=1 gets no SPI activity; spi_ss stays high.
  - It goes IDLE -> ERR -> IDLE, and wb_err_o pulses one cycle in the cycle after acceptance.
  - wb_ack_o stays 0 and wb_dat_o is unchanged.
- Not defined: wb_err_o is tied 0, and bit 7 is ignored, so address 8'h85 aliases to 8'h05.

Test Plan:
- Write, CLK_DIV=4, SS_GAP=4, addr 8'h05, data 8'hA5:
  - MOSI frames decode to 8'h85 then 8'hA5.
  - Each frame has spi_ss low for 72 cycles with 8 falling sck edges.
  - A single wb_ack_o pulse arrives 153 cycles after acceptance.
- Read addr 8'h00 with the slave model driving 8'h3C in frame 1: MOSI sends 8'h00, 8'h00; wb_dat_o=8'h3C in the ack cycle and holds after.
- Loopback with an spi_ctrl instance (its wb_ack_i tied to its wb_stb_o, wb_dat_i=8'h42):
  - Write 8'h01 to addr 0: spi_ctrl shows wb_we_o=1, wb_addr_o=0, wb_dat_o=8'h01.
  - Read addr 0: returns 8'h42.
- Reset low during frame 0 bit 3:
  - spi_ss=1, spi_sck=1 and spi_mosi=0 before the next clk edge.
  - No ack occurs.
  - A following write of 8'h7E to addr 8'h10 completes correctly (8'h90, 8'h7E).
- Change wb_dat_i from 8'hA5 to 8'h5A one cycle after acceptance: frame 1 still sends 8'hA5.
- Access to addr 8'h80:
  - With SPI_HOST_ADDR_CHK_EN: wb_err_o pulses once, spi_ss never goes low, no ack.
  - Without the macro: a read sends command 8'h00 and acks normally.

Source files
------------

// File: rtl/spi_host_ctrl.sv
// spi_host_ctrl: SPI host (master) that turns one Wishbone-style slave access
// into a two-frame SPI sequence:
//   frame 0 = command byte {we, addr[6:0]}
//   frame 1 = write data (write) or 8'h00 while clocking in read data (read)
//
// Optional feature macro: SPI_HOST_ADDR_CHK_EN
//   defined   : wb_addr_i[7]=1 is rejected with a one-cycle wb_err_o pulse and
//               no SPI activity.
//   undefined : wb_err_o is tied 0 and wb_addr_i[7] is ignored.
//
// Handshake: the host raises wb_stb_i with address/data/we stable and holds it
// until wb_ack_o (or wb_err_o) pulses for exactly one cycle. A request is taken
// only in IDLE on a rising clk edge with wb_stb_i=1; the inputs are captured
// there and ignored afterwards.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   wb_addr_i  register address (bits [6:0] are sent)
//   wb_dat_i   write data
//   wb_dat_o   read data, updated with wb_ack_o on reads
//   wb_stb_i   request strobe
//   wb_we_i    1 = write, 0 = read
//   wb_ack_o   one-cycle completion pulse
//   wb_err_o   one-cycle error pulse
//   spi_sck    SPI clock, idles high
//   spi_mosi   host-to-slave data, MSB first
//   spi_miso   slave-to-host data
//   spi_ss     active-low slave select
//   dbg_state  current FSM state encoding, for observation only
module spi_host_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wb_addr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  output logic       wb_err_o,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_ss,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    F0_LEAD  = 4'd1,
    F0_SHIFT = 4'd2,
    F0_TRAIL = 4'd3,
    GAP0     = 4'd4,
    F1_LEAD  = 4'd5,
    F1_SHIFT = 4'd6,
    F1_TRAIL = 4'd7,
    GAP1     = 4'd8,
    ACK      = 4'd9,
    ERR      = 4'd10
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(SS_GAP - 1);

  state_t      state;
  logic [15:0] cnt;    // clk cycles within the current LEAD/half-period/TRAIL/GAP
  logic [3:0]  half;   // SCK half-period index within SHIFT; even = low, odd = high
  logic [7:0]  tx_sh;  // frame byte, current bit always at [7]
  logic [7:0]  rx_sh;
  logic [7:0]  dat_q;
  logic        we_q;
  logic [7:0]  f1_byte;

  assign f1_byte   = we_q ? dat_q : 8'h00;
  assign dbg_state = state;

`ifndef SPI_HOST_ADDR_CHK_EN
  logic unused_addr_msb;
  assign unused_addr_msb = wb_addr_i[7];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      half     <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      wb_dat_o <= 8'h00;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      spi_sck  <= 1'b1;
      spi_mosi <= 1'b0;
      spi_ss   <= 1'b1;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_stb_i) begin
`ifdef SPI_HOST_ADDR_CHK_EN
            if (wb_addr_i[7]) begin
              state    <= ERR;
              wb_err_o <= 1'b1;
            end else
`endif
            begin
              state    <= F0_LEAD;
              cnt      <= '0;
              we_q     <= wb_we_i;
              dat_q    <= wb_dat_i;
              tx_sh    <= {wb_we_i, wb_addr_i[6:0]};
              spi_ss   <= 1'b0;
              spi_mosi <= wb_we_i;
            end
          end
        end

        F0_LEAD, F1_LEAD: begin
          if (cnt == DIV_LAST) begin
            // first falling SCK edge; MISO is sampled on the same cycle
            state   <= (state == F0_LEAD) ? F0_SHIFT : F1_SHIFT;
            cnt     <= '0;
            half    <= '0;
            spi_sck <= 1'b0;
            rx_sh   <= {rx_sh[6:0], spi_miso};
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        F0_SHIFT, F1_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt  <= '0;
            half <= half + 4'd1;
            if (half == 4'd15) begin
              // SCK already high after the 8th rising edge
              state <= (state == F0_SHIFT) ? F0_TRAIL : F1_TRAIL;
            end else if (!half[0]) begin
              spi_sck <= 1'b1;
              // the 8th rising edge leaves bit 0 on MOSI through TRAIL
              if (half != 4'd14) begin
                spi_mosi <= tx_sh[6];
                tx_sh    <= {tx_sh[6:0], 1'b0};
              end
            end else begin
              spi_sck <= 1'b0;
              rx_sh   <= {rx_sh[6:0], spi_miso};
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        F0_TRAIL, F1_TRAIL: begin
          if (cnt == DIV_LAST) begin
            state    <= (state == F0_TRAIL) ? GAP0 : GAP1;
            cnt      <= '0;
            spi_ss   <= 1'b1;
            spi_mosi <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        GAP0: begin
          if (cnt == GAP_LAST) begin
            state    <= F1_LEAD;
            cnt      <= '0;
            tx_sh    <= f1_byte;
            spi_ss   <= 1'b0;
            spi_mosi <= f1_byte[7];
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        GAP1: begin
          if (cnt == GAP_LAST) begin
            state <= ACK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ACK: begin
          wb_ack_o <= 1'b1;
          // frame 0 rx bits have been fully shifted out by frame 1
          if (!we_q) wb_dat_o <= rx_sh;
          state <= IDLE;
        end

        ERR: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_ctrl.sv
module tb_spi_host_ctrl;

  localparam int ACK_LAT = 153;  // 2*(18*4+4)+1
  localparam int SS_LOW  = 72;   // 18*4

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wb_addr_i = 8'h00;
  logic [7:0] wb_dat_i = 8'h00;
  logic [7:0] wb_dat_o;
  logic       wb_stb_i = 1'b0;
  logic       wb_we_i = 1'b0;
  logic       wb_ack_o;
  logic       wb_err_o;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_ss;
  logic [3:0] dbg_state;

  spi_host_ctrl #(.CLK_DIV(4), .SS_GAP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_addr_i (wb_addr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_ss    (spi_ss),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    bit         is_err;
    bit         is_read;
    logic [7:0] rd;
    int         accept;
  } resp_t;

  logic [7:0] exp_q[$];    // expected MOSI frame bytes
  logic [7:0] slave_q[$];  // bytes the slave model returns, one per frame
  resp_t      resp_q[$];

  int total = 0;
  int bad = 0;
  int ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  logic [7:0] sl_sh = 8'h00;
  logic       sl_ss_prev = 1'b1;
  logic       sl_sck_prev = 1'b1;
  assign spi_miso = sl_sh[7];

  initial forever begin
    @(negedge clk);
    if (sl_ss_prev && !spi_ss) begin
      if (slave_q.size() > 0) sl_sh = slave_q.pop_front();
      else sl_sh = 8'h00;
    end else if (!spi_ss && !sl_sck_prev && spi_sck) begin
      sl_sh = {sl_sh[6:0], 1'b0};
    end
    sl_ss_prev  = spi_ss;
    sl_sck_prev = spi_sck;
  end

  // ---------------- SPI frame monitor ----------------
  logic       fm_ss_prev = 1'b1;
  logic       fm_sck_prev = 1'b1;
  bit         in_frame = 1'b0;
  bit         edge_bad = 1'b0;
  int         low_cnt = 0;
  int         fall_cnt = 0;
  logic [7:0] mosi_byte = 8'h00;
  logic [7:0] exp_byte;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      in_frame = 1'b0;
    end else begin
      if (fm_ss_prev && !spi_ss) begin
        in_frame  = 1'b1;
        low_cnt   = 0;
        fall_cnt  = 0;
        mosi_byte = 8'h00;
        edge_bad  = 1'b0;
      end
      if (in_frame) begin
        if (!spi_ss) low_cnt++;
        if (fm_sck_prev && !spi_sck) begin
          fall_cnt++;
          mosi_byte = {mosi_byte[6:0], spi_mosi};
        end
        if (!fm_sck_prev && spi_sck && (fm_ss_prev != spi_ss)) edge_bad = 1'b1;
        if (!fm_ss_prev && spi_ss) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %0h expected none", mosi_byte);
          end else begin
            exp_byte = exp_q.pop_front();
            chk("frame_byte", 32'(mosi_byte), 32'(exp_byte));
            chk("frame_falls", 32'(fall_cnt), 32'd8);
            chk("frame_ss_low", 32'(low_cnt), 32'(SS_LOW));
            chk("frame_sck_ss_edge", 32'(edge_bad), 32'd0);
          end
        end
      end
    end
    fm_ss_prev  = spi_ss;
    fm_sck_prev = spi_sck;
  end

  // ---------------- response monitor ----------------
  resp_t e;
  initial forever begin
    @(negedge clk);
    if (reset && (wb_ack_o || wb_err_o)) begin
      ack_cnt++;
      if (resp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_response: ack=%0b err=%0b expected none", wb_ack_o, wb_err_o);
      end else begin
        e = resp_q.pop_front();
        chk("resp_err", 32'(wb_err_o), 32'(e.is_err));
        chk("resp_ack", 32'(wb_ack_o), 32'(!e.is_err));
        chk("resp_latency", 32'(cyc - e.accept), e.is_err ? 32'd0 : 32'(ACK_LAT));
        if (e.is_read && !e.is_err) chk("read_data", 32'(wb_dat_o), 32'(e.rd));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input logic [7:0] addr, input logic [7:0] dat, input logic we,
                           input logic [7:0] f0, input logic [7:0] f1,
                           input logic [7:0] s1, input bit exp_err, input bit change_dat);
    resp_t r;
    bit    done;
    if (!exp_err) begin
      exp_q.push_back(f0);
      exp_q.push_back(f1);
      slave_q.push_back(~f0);
      slave_q.push_back(s1);
    end
    @(negedge clk);
    wb_addr_i = addr;
    wb_dat_i  = dat;
    wb_we_i   = we;
    wb_stb_i  = 1'b1;
    @(posedge clk);
    #1;
    r.is_err  = exp_err;
    r.is_read = !we;
    r.rd      = s1;
    r.accept  = cyc;
    resp_q.push_back(r);
    done = 1'b0;
    if (change_dat) begin
      @(posedge clk);
      #1 wb_dat_i = 8'h5A;
    end
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) done = 1'b1;
    end
    if (!done) chk("response_timeout", 32'd0, 32'd1);
    wb_stb_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int acks_before;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ss", 32'(spi_ss), 32'd1);
    chk("reset_sck", 32'(spi_sck), 32'd1);
    chk("reset_mosi", 32'(spi_mosi), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ack", 32'(wb_ack_o), 32'd0);
    chk("reset_err", 32'(wb_err_o), 32'd0);
    chk("reset_dat_o", 32'(wb_dat_o), 32'h00);
    chk("reset_state", 32'(dbg_state), 32'd0);

    // write 05/A5
    do_access(8'h05, 8'hA5, 1'b1, 8'h85, 8'hA5, 8'h00, 1'b0, 1'b0);
    // read 00, slave returns 3C
    do_access(8'h00, 8'h77, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("read_hold", 32'(wb_dat_o), 32'h3C);
    // write 01 to addr 0; read data register must not change
    do_access(8'h00, 8'h01, 1'b1, 8'h80, 8'h01, 8'hEE, 1'b0, 1'b0);
    chk("write_keeps_dat_o", 32'(wb_dat_o), 32'h3C);
    // read 7F, slave returns C3
    do_access(8'h7F, 8'h00, 1'b0, 8'h7F, 8'h00, 8'hC3, 1'b0, 1'b0);

    // reset during frame 0 bit 3 of a write
    acks_before = ack_cnt;
    @(negedge clk);
    wb_addr_i = 8'h10;
    wb_dat_i  = 8'h7E;
    wb_we_i   = 1'b1;
    wb_stb_i  = 1'b1;
    @(posedge clk);
    repeat (34) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_ss", 32'(spi_ss), 32'd1);
    chk("abort_sck", 32'(spi_sck), 32'd1);
    chk("abort_mosi", 32'(spi_mosi), 32'd0);
    chk("abort_dat_o", 32'(wb_dat_o), 32'h00);
    wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    chk("abort_no_ack", 32'(ack_cnt), 32'(acks_before));
    do_access(8'h10, 8'h7E, 1'b1, 8'h90, 8'h7E, 8'h00, 1'b0, 1'b0);

    // data input changes after acceptance are ignored
    do_access(8'h22, 8'hA5, 1'b1, 8'hA2, 8'hA5, 8'h00, 1'b0, 1'b1);

    // address with bit 7 set
`ifdef SPI_HOST_ADDR_CHK_EN
    do_access(8'h80, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    chk("err_keeps_dat_o", 32'(wb_dat_o), 32'h00);
`else
    do_access(8'h80, 8'h00, 1'b0, 8'h00, 8'h00, 8'h99, 1'b0, 1'b0);
`endif

    repeat (20) @(negedge clk);
    chk("frames_drained", 32'(exp_q.size()), 32'd0);
    chk("responses_drained", 32'(resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
